// File: rtl/pio_wr_replay.sv
// -----------------------------------------------------------------------------
// pio_wr_replay
//
// Purpose:
//   Replays the registered write mirror of a PIO write-only table into a remote
//   shadow copy. After reset the whole shadow table is first swept to INIT_VAL.
//   Mirrored writes are then replayed from a small FIFO, in arrival order.
//   Writes that arrive during the sweep are queued behind it, so they still
//   land after the INIT_VAL entries.
//
// Optional feature:
//   PIO_WR_REPLAY_PARITY_EN - adds o_sh_wr_par, the even parity (XOR
//   reduction) of o_sh_wr_data. It is registered with the data.
//
// Ports:
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_wr_active    one-cycle pulse: mirrored write occurred
//   i_wr_addr      mirrored write address
//   i_wr_data      mirrored write data
//   o_sh_wr_valid  shadow write request
//   i_sh_wr_ready  shadow accepts the request
//   o_sh_wr_addr   shadow write address
//   o_sh_wr_data   shadow write data
//   o_init_busy    init sweep in progress
//   o_ovf_sticky   at least one mirrored write was dropped
//   i_ovf_clr      clears o_ovf_sticky (a drop in the same cycle wins)
//   o_fifo_level   FIFO occupancy, excluding the output register
//   o_dbg_state    FSM state: 0 = INIT sweep, 1 = RUN replay
//
// Handshake:
//   A shadow write transfers on every cycle where o_sh_wr_valid and
//   i_sh_wr_ready are both 1. While valid=1 and ready=0, the address and data
//   hold stable. Valid only drops after a transfer.
// -----------------------------------------------------------------------------
module pio_wr_replay #(
   parameter int                WIDTH       = 20,
   parameter int                DEPTH_NBITS = 1,
   parameter int                FIFO_NBITS  = 3,
   parameter logic [WIDTH-1:0]  INIT_VAL    = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_wr_active,
   input  logic [DEPTH_NBITS-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]       i_wr_data,
   output logic                   o_sh_wr_valid,
   input  logic                   i_sh_wr_ready,
   output logic [DEPTH_NBITS-1:0] o_sh_wr_addr,
   output logic [WIDTH-1:0]       o_sh_wr_data,
`ifdef PIO_WR_REPLAY_PARITY_EN
   output logic                   o_sh_wr_par,
`endif
   output logic                   o_init_busy,
   output logic                   o_ovf_sticky,
   input  logic                   i_ovf_clr,
   output logic [FIFO_NBITS:0]    o_fifo_level,
   output logic                   o_dbg_state
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [DEPTH_NBITS-1:0] LAST_ADDR = {DEPTH_NBITS{1'b1}};
   localparam logic [FIFO_NBITS:0]    LEVEL_MAX = {1'b1, {FIFO_NBITS{1'b0}}};

   state_t                      r_state, w_state_nxt;
   logic [DEPTH_NBITS-1:0]      r_sweep, w_sweep_nxt;
   logic                        r_valid, w_valid_nxt;
   logic [DEPTH_NBITS-1:0]      r_addr, w_addr_nxt;
   logic [WIDTH-1:0]            r_data, w_data_nxt;
   logic                        r_init_busy;
   logic                        r_ovf;

   logic [DEPTH_NBITS+WIDTH-1:0] r_mem [2**FIFO_NBITS];
   logic [FIFO_NBITS-1:0]        r_wptr, r_rptr;
   logic [FIFO_NBITS:0]          r_level;

   logic                         w_xfer, w_out_free, w_pop, w_full, w_push, w_drop;
   logic [DEPTH_NBITS+WIDTH-1:0] w_head;

   assign w_xfer     = r_valid & i_sh_wr_ready;
   assign w_out_free = ~r_valid | w_xfer;
   // The FIFO only feeds the output register once the sweep is done.
   assign w_pop      = (r_state == ST_RUN) & w_out_free & (r_level != '0);
   // A pop in the same cycle frees a slot, so a push at full level is still taken.
   assign w_full     = (r_level == LEVEL_MAX) & ~w_pop;
   assign w_push     = i_wr_active & ~w_full;
   assign w_drop     = i_wr_active & w_full;
   assign w_head     = r_mem[r_rptr];

   // Next-state and output-register load.
   always_comb begin
      w_state_nxt = r_state;
      w_sweep_nxt = r_sweep;
      w_valid_nxt = r_valid;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      if (r_state == ST_INIT) begin
         if (!r_valid) begin
            // The first cycle out of reset: present sweep entry 0.
            w_valid_nxt = 1'b1;
            w_addr_nxt  = r_sweep;
            w_data_nxt  = INIT_VAL;
         end else if (w_xfer) begin
            w_sweep_nxt = r_sweep + 1'b1;
            if (r_sweep == LAST_ADDR) begin
               w_state_nxt = ST_RUN;
               w_valid_nxt = 1'b0;
            end else begin
               w_addr_nxt = r_sweep + 1'b1;
               w_data_nxt = INIT_VAL;
            end
         end
      end else begin
         if (w_pop) begin
            w_valid_nxt = 1'b1;
            w_addr_nxt  = w_head[WIDTH +: DEPTH_NBITS];
            w_data_nxt  = w_head[WIDTH-1:0];
         end else if (w_xfer) begin
            w_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= ST_INIT;
         r_sweep     <= '0;
         r_valid     <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_init_busy <= 1'b1;
         r_ovf       <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep     <= w_sweep_nxt;
         r_valid     <= w_valid_nxt;
         r_addr      <= w_addr_nxt;
         r_data      <= w_data_nxt;
         r_init_busy <= (w_state_nxt == ST_INIT);
         if (w_drop)
            r_ovf <= 1'b1;
         else if (i_ovf_clr)
            r_ovf <= 1'b0;
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)
            r_level <= r_level + 1'b1;
         else if (w_pop && !w_push)
            r_level <= r_level - 1'b1;
      end
   end

   // Storage needs no reset: the pointers and the level define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wptr] <= {i_wr_addr, i_wr_data};
   end

`ifdef PIO_WR_REPLAY_PARITY_EN
   logic r_par;
   // The data only changes on a load, so the parity follows it and holds under a stall.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_par <= 1'b0;
      else
         r_par <= ^w_data_nxt;
   end
   assign o_sh_wr_par = r_par;
`endif

   assign o_sh_wr_valid = r_valid;
   assign o_sh_wr_addr  = r_addr;
   assign o_sh_wr_data  = r_data;
   assign o_init_busy   = r_init_busy;
   assign o_ovf_sticky  = r_ovf;
   assign o_fifo_level  = r_level;
   assign o_dbg_state   = (r_state == ST_RUN);

endmodule

// File: tb/tb_pio_wr_replay.sv
// -----------------------------------------------------------------------------
// tb_pio_wr_replay
//
// Self-checking bench for pio_wr_replay (DEPTH_NBITS=2, FIFO_NBITS=3,
// INIT_VAL=5).
// Model: an ordered list of shadow writes that must appear. After each reset
// it holds the sweep entries (tagged as sweep), followed by every mirrored
// write the bench knows is accepted. A negedge process pops this list on every
// transfer and compares against it. The same process checks stability under a
// stall and checks o_init_busy against the number of sweep transfers seen.
// Directed steps pin latency, levels and overflow behaviour with literal values.
// -----------------------------------------------------------------------------
module tb_pio_wr_replay;

   localparam int AW = 2;
   localparam int DW = 20;
   localparam int FW = 3;
   localparam logic [DW-1:0] IV = 20'd5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_active = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          sh_valid;
   logic          sh_ready = 1'b0;
   logic [AW-1:0] sh_addr;
   logic [DW-1:0] sh_data;
   logic          init_busy;
   logic          ovf_sticky;
   logic          ovf_clr = 1'b0;
   logic [FW:0]   fifo_level;
   logic          dbg_state;

   int n_checks = 0;
   int n_err    = 0;

   // {is_sweep, addr, data}
   logic [AW+DW:0] exp_q[$];
   int             sweep_seen = 0;

   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_data;

   pio_wr_replay #(
      .WIDTH(DW), .DEPTH_NBITS(AW), .FIFO_NBITS(FW), .INIT_VAL(IV)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_wr_active(wr_active),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .o_sh_wr_valid(sh_valid),
      .i_sh_wr_ready(sh_ready),
      .o_sh_wr_addr(sh_addr),
      .o_sh_wr_data(sh_data),
      .o_init_busy(init_busy),
      .o_ovf_sticky(ovf_sticky),
      .i_ovf_clr(ovf_clr),
      .o_fifo_level(fifo_level),
      .o_dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: runs every cycle, away from the active edge.
   always @(negedge clk) begin
      logic [AW+DW:0] e;
      if (!rst_n) begin
         prev_stall = 1'b0;
         sweep_seen = 0;
      end else begin
         check("init_busy_model", {31'd0, init_busy}, {31'd0, (sweep_seen < (1 << AW))});
         if (prev_stall) begin
            check("stall_valid", {31'd0, sh_valid}, 32'd1);
            check("stall_addr", {30'd0, sh_addr}, {30'd0, prev_addr});
            check("stall_data", {12'd0, sh_data}, {12'd0, prev_data});
         end
         if (sh_valid && sh_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_xfer", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("xfer_addr", {30'd0, sh_addr}, {30'd0, e[DW +: AW]});
               check("xfer_data", {12'd0, sh_data}, {12'd0, e[DW-1:0]});
               if (e[AW+DW]) sweep_seen++;
            end
         end
         prev_stall = sh_valid && !sh_ready;
         prev_addr  = sh_addr;
         prev_data  = sh_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset for two edges, check the reset values, reload the model with the sweep.
   task automatic do_reset();
      rst_n     = 1'b0;
      wr_active = 1'b0;
      ovf_clr   = 1'b0;
      exp_q.delete();
      step();
      check("rst_valid", {31'd0, sh_valid}, 32'd0);
      check("rst_busy", {31'd0, init_busy}, 32'd1);
      check("rst_level", {28'd0, fifo_level}, 32'd0);
      check("rst_ovf", {31'd0, ovf_sticky}, 32'd0);
      check("rst_addr", {30'd0, sh_addr}, 32'd0);
      check("rst_data", {12'd0, sh_data}, 32'd0);
      check("rst_state", {31'd0, dbg_state}, 32'd0);
      step();
      for (int a = 0; a < (1 << AW); a++) exp_q.push_back({1'b1, AW'(a), IV});
      rst_n = 1'b1;
   endtask

   // One-cycle mirrored write. 'accept' is the hand-derived fate of the push.
   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
      wr_active = 1'b1;
      wr_addr   = a;
      wr_data   = d;
      if (accept) exp_q.push_back({1'b0, a, d});
      step();
      wr_active = 1'b0;
   endtask

   task automatic drain();
      sh_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      check("drain_empty", exp_q.size(), 32'd0);
      step();
      step();
      check("drain_valid", {31'd0, sh_valid}, 32'd0);
      check("drain_level", {28'd0, fifo_level}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Sweep with ready held high: addresses 0..3 on consecutive cycles.
      sh_ready = 1'b1;
      do_reset();
      for (int a = 0; a < 4; a++) begin
         step();
         check("sweep_valid", {31'd0, sh_valid}, 32'd1);
         check("sweep_addr", {30'd0, sh_addr}, a);
         check("sweep_data", {12'd0, sh_data}, 32'd5);
         check("sweep_busy", {31'd0, init_busy}, 32'd1);
      end
      step();
      check("sweep_done_valid", {31'd0, sh_valid}, 32'd0);
      check("sweep_done_busy", {31'd0, init_busy}, 32'd0);
      check("sweep_done_state", {31'd0, dbg_state}, 32'd1);

      // Write during the sweep while the shadow is stalled.
      sh_ready = 1'b0;
      do_reset();
      step();
      push(2'd1, 20'hABCDE, 1'b1);
      for (int i = 0; i < 8; i++) step();
      check("dsweep_level", {28'd0, fifo_level}, 32'd1);
      check("dsweep_addr", {30'd0, sh_addr}, 32'd0);
      check("dsweep_busy", {31'd0, init_busy}, 32'd1);
      drain();

      // Latency from an idle RUN state: push at edge N, valid after N+1, for one cycle.
      sh_ready  = 1'b1;
      wr_active = 1'b1;
      wr_addr   = 2'd2;
      wr_data   = 20'h12345;
      exp_q.push_back({1'b0, 2'd2, 20'h12345});
      step();
      wr_active = 1'b0;
      check("lat_n_valid", {31'd0, sh_valid}, 32'd0);
      check("lat_n_level", {28'd0, fifo_level}, 32'd1);
      step();
      check("lat_n1_valid", {31'd0, sh_valid}, 32'd1);
      check("lat_n1_addr", {30'd0, sh_addr}, 32'd2);
      check("lat_n1_data", {12'd0, sh_data}, 32'h12345);
      step();
      check("lat_n2_valid", {31'd0, sh_valid}, 32'd0);

      // Stall stability: A held for 8 cycles, then A, B, C back to back.
      sh_ready = 1'b0;
      push(2'd3, 20'h11111, 1'b1);
      push(2'd0, 20'h22222, 1'b1);
      push(2'd2, 20'h33333, 1'b1);
      for (int i = 0; i < 8; i++) step();
      check("stall_hold_addr", {30'd0, sh_addr}, 32'd3);
      check("stall_hold_data", {12'd0, sh_data}, 32'h11111);
      check("stall_level", {28'd0, fifo_level}, 32'd2);
      sh_ready = 1'b1;
      step();
      check("stall_b_addr", {30'd0, sh_addr}, 32'd0);
      check("stall_b_data", {12'd0, sh_data}, 32'h22222);
      step();
      check("stall_c_addr", {30'd0, sh_addr}, 32'd2);
      check("stall_c_data", {12'd0, sh_data}, 32'h33333);
      step();
      check("stall_end_valid", {31'd0, sh_valid}, 32'd0);

      // Overflow: 1 in the output register + 8 in the FIFO, the 10th is dropped.
      sh_ready = 1'b0;
      for (int i = 1; i <= 10; i++) push(AW'(i), DW'(32'h100 + i), i <= 9);
      check("ovf_level", {28'd0, fifo_level}, 32'd8);
      check("ovf_set", {31'd0, ovf_sticky}, 32'd1);
      check("ovf_head", {12'd0, sh_data}, 32'h101);
      ovf_clr = 1'b1;
      push(2'd3, 20'h0BEEF, 1'b0);
      ovf_clr = 1'b0;
      check("ovf_clr_vs_drop", {31'd0, ovf_sticky}, 32'd1);
      check("ovf_level_hold", {28'd0, fifo_level}, 32'd8);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_cleared", {31'd0, ovf_sticky}, 32'd0);
      drain();

      // Reset mid-replay with five entries queued.
      sh_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(AW'(i), DW'(32'h2000 + i), 1'b1);
      check("mid_level", {28'd0, fifo_level}, 32'd5);
      sh_ready = 1'b1;
      do_reset();
      step();
      check("mid_restart_valid", {31'd0, sh_valid}, 32'd1);
      check("mid_restart_addr", {30'd0, sh_addr}, 32'd0);
      check("mid_restart_data", {12'd0, sh_data}, 32'd5);
      drain();
      check("final_busy", {31'd0, init_busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Watchdog: the directed sequence is far shorter than this.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
